// File: rtl/ioctl_streamer_if.sv
// ROM source request bus plus the ioctl download write bus driven by ioctl_streamer.
interface ioctl_streamer_if;
   localparam int unsigned SRC_AW = 20;
   localparam int unsigned IO_AW  = 25;
   localparam int unsigned DW     = 8;

   logic [SRC_AW-1:0] src_addr;
   logic              src_req;
   logic              src_ack;
   logic              src_valid;
   logic [DW-1:0]     src_data;

   logic              ioctl_download;
   logic [DW-1:0]     ioctl_index;
   logic [IO_AW-1:0]  ioctl_addr;
   logic [DW-1:0]     ioctl_data;
   logic              ioctl_wr;

   modport master (
      output src_addr, src_req, ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr,
      input  src_ack, src_valid, src_data
   );

   modport slave (
      input  src_addr, src_req, ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr,
      output src_ack, src_valid, src_data
   );
endinterface

// File: rtl/ioctl_streamer.sv
// Streams game index, DIP bytes and ROM image over the ioctl download bus,
// fetching ROM bytes one at a time from a req/ack/valid source.
module ioctl_streamer #(
   parameter int unsigned WR_GAP = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       game_index,
   input  logic [7:0]       dip_1,
   input  logic [7:0]       dip_2,
   input  logic [19:0]      rom_len,
   output logic             busy,
   output logic             done,
   ioctl_streamer_if.master bus
);

   localparam int unsigned CNT_W    = 20;
   localparam int unsigned ADDR_W   = 25;
   localparam int unsigned DW       = 8;
   localparam int unsigned GAP_W    = 4;
   localparam int unsigned DIP_W    = 3;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP);
   localparam logic [DW-1:0]    IDX_GAME = 8'd1;
   localparam logic [DW-1:0]    IDX_DIP  = 8'd254;
   localparam logic [DW-1:0]    IDX_ROM  = 8'd0;

   typedef enum logic [2:0] {
      IDLE, IDX, DIP, ROM_REQ, ROM_WAIT, ROM_WR, GAP, FINISH
   } state_t;

   state_t              state_q, state_d;
   state_t              phase_q, phase_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                download_q, download_d;
   logic [DW-1:0]       index_q, index_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DW-1:0]       data_q, data_d;
   logic                wr_q, wr_d;
   logic [CNT_W-1:0]    src_addr_q, src_addr_d;
   logic                src_req_q, src_req_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [CNT_W-1:0]    byte_q, byte_d;
   logic [DIP_W-1:0]    dip_idx_q, dip_idx_d;
   logic [DW-1:0]       dip1_q, dip1_d;
   logic [DW-1:0]       dip2_q, dip2_d;
   logic [CNT_W-1:0]    rom_len_q, rom_len_d;
   logic [DW-1:0]       rom_byte_q, rom_byte_d;

   logic [CNT_W-1:0]    last_byte_c;
   logic [CNT_W-1:0]    byte_nxt_c;
   logic [DIP_W-1:0]    dip_nxt_c;

   assign last_byte_c = rom_len_q - CNT_W'(1);
   assign byte_nxt_c  = byte_q + CNT_W'(1);
   assign dip_nxt_c   = dip_idx_q + DIP_W'(1);

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         phase_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         download_q <= 1'b0;
         index_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_q       <= 1'b0;
         src_addr_q <= '0;
         src_req_q  <= 1'b0;
         gap_q      <= '0;
         byte_q     <= '0;
         dip_idx_q  <= '0;
         dip1_q     <= '0;
         dip2_q     <= '0;
         rom_len_q  <= '0;
         rom_byte_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         download_q <= download_d;
         index_q    <= index_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_q       <= wr_d;
         src_addr_q <= src_addr_d;
         src_req_q  <= src_req_d;
         gap_q      <= gap_d;
         byte_q     <= byte_d;
         dip_idx_q  <= dip_idx_d;
         dip1_q     <= dip1_d;
         dip2_q     <= dip2_d;
         rom_len_q  <= rom_len_d;
         rom_byte_q <= rom_byte_d;
      end
   end

   // Next state and next output values; every write reloads the spacing counter
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      download_d = download_q;
      index_d    = index_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_d       = 1'b0;
      src_addr_d = src_addr_q;
      src_req_d  = src_req_q;
      gap_d      = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);
      byte_d     = byte_q;
      dip_idx_d  = dip_idx_q;
      dip1_d     = dip1_q;
      dip2_d     = dip2_q;
      rom_len_d  = rom_len_q;
      rom_byte_d = rom_byte_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = IDX;
               busy_d     = 1'b1;
               download_d = 1'b1;
               index_d    = IDX_GAME;
               addr_d     = '0;
               data_d     = {4'h0, game_index};
               wr_d       = 1'b1;
               gap_d      = GAP_LOAD;
               dip1_d     = dip_1;
               dip2_d     = dip_2;
               rom_len_d  = rom_len;
            end
         end

         IDX: begin
            state_d    = GAP;
            phase_d    = DIP;
            download_d = 1'b0;
            index_d    = IDX_DIP;
         end

         DIP: begin
            if (wr_q && dip_idx_q == DIP_W'(7)) begin
               state_d    = GAP;
               phase_d    = (rom_len_q == '0) ? FINISH : ROM_REQ;
               download_d = 1'b0;
               index_d    = IDX_ROM;
            end else if (gap_q == '0) begin
               dip_idx_d = dip_nxt_c;
               addr_d    = ADDR_W'(dip_nxt_c);
               data_d    = (dip_idx_q == '0) ? dip2_q : 8'hFF;
               wr_d      = 1'b1;
               gap_d     = GAP_LOAD;
            end
         end

         ROM_REQ: begin
            // ack and valid together count as ack followed by valid
            if (bus.src_ack) begin
               src_req_d = 1'b0;
               if (bus.src_valid) begin
                  rom_byte_d = bus.src_data;
                  state_d    = ROM_WR;
               end else begin
                  state_d = ROM_WAIT;
               end
            end
         end

         ROM_WAIT: begin
            if (bus.src_valid) begin
               rom_byte_d = bus.src_data;
               state_d    = ROM_WR;
            end
         end

         ROM_WR: begin
            if (wr_q) begin
               if (byte_q == last_byte_c) begin
                  state_d    = GAP;
                  phase_d    = FINISH;
                  download_d = 1'b0;
               end else begin
                  byte_d     = byte_nxt_c;
                  src_addr_d = byte_nxt_c;
                  src_req_d  = 1'b1;
                  state_d    = ROM_REQ;
               end
            end else if (gap_q == '0) begin
               addr_d = ADDR_W'(byte_q);
               data_d = rom_byte_q;
               wr_d   = 1'b1;
               gap_d  = GAP_LOAD;
            end
         end

         GAP: begin
            // download stays low for exactly WR_GAP cycles after the last write of a phase
            if (gap_q == '0) begin
               state_d = phase_q;
               unique case (phase_q)
                  DIP: begin
                     download_d = 1'b1;
                     dip_idx_d  = '0;
                     addr_d     = '0;
                     data_d     = dip1_q;
                     wr_d       = 1'b1;
                     gap_d      = GAP_LOAD;
                  end
                  ROM_REQ: begin
                     download_d = 1'b1;
                     byte_d     = '0;
                     src_addr_d = '0;
                     src_req_d  = 1'b1;
                  end
                  FINISH: begin
                     done_d = 1'b1;
                  end
                  default: begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               endcase
            end
         end

         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign bus.ioctl_download = download_q;
   assign bus.ioctl_index    = index_q;
   assign bus.ioctl_addr     = addr_q;
   assign bus.ioctl_data     = data_q;
   assign bus.ioctl_wr       = wr_q;
   assign bus.src_addr       = src_addr_q;
   assign bus.src_req        = src_req_q;

endmodule

// File: tb/tb_ioctl_streamer.sv
// Scoreboarded bench for ioctl_streamer: WR_GAP=3 instance with a delay-programmable
// ROM source, plus a WR_GAP=1 instance whose source answers in the request cycle.
module tb_ioctl_streamer;

   typedef struct packed {
      logic [7:0]  idx;
      logic [24:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [3:0]  gi;
      logic [7:0]  d1;
      logic [7:0]  d2;
      logic [19:0] len;
      int          ack_dly;
      int          val_dly;
      int          exp_wr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, start1;
   logic [3:0]  game_index;
   logic [7:0]  dip_1, dip_2;
   logic [19:0] rom_len;
   logic [19:0] rom_len1;
   logic        busy, done, busy1, done1;

   always #5 clk = ~clk;

   ioctl_streamer_if bus();
   ioctl_streamer_if bus1();

   ioctl_streamer #(.WR_GAP(3)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .game_index(game_index),
      .dip_1(dip_1), .dip_2(dip_2), .rom_len(rom_len), .busy(busy), .done(done), .bus(bus)
   );

   ioctl_streamer #(.WR_GAP(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .game_index(game_index),
      .dip_1(dip_1), .dip_2(dip_2), .rom_len(rom_len1), .busy(busy1), .done(done1), .bus(bus1)
   );

   assign bus1.src_ack   = bus1.src_req;
   assign bus1.src_valid = bus1.src_req;
   assign bus1.src_data  = bus1.src_addr[7:0] ^ 8'h33;

   int n_checks = 0;
   int n_fail   = 0;
   wr_t exp_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_seq(input logic [3:0] gi, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [19:0] len);
      wr_t e;
      e.idx = 8'd1; e.addr = 25'd0; e.data = {4'h0, gi};
      exp_q.push_back(e);
      for (int i = 0; i < 8; i++) begin
         e.idx  = 8'd254;
         e.addr = 25'(i);
         e.data = (i == 0) ? d1 : ((i == 1) ? d2 : 8'hFF);
         exp_q.push_back(e);
      end
      for (int n = 0; n < int'(len); n++) begin
         e.idx  = 8'd0;
         e.addr = 25'(n);
         e.data = 8'(n) ^ 8'h33;
         exp_q.push_back(e);
      end
   endtask

   // ROM source model for the WR_GAP=3 instance
   int          ack_dly = 0;
   int          val_dly = 1;
   logic [19:0] src_a;
   initial begin
      bus.src_ack   = 1'b0;
      bus.src_valid = 1'b0;
      bus.src_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.src_req && reset_n) begin
            src_a = bus.src_addr;
            repeat (ack_dly) @(negedge clk);
            bus.src_ack = 1'b1;
            if (val_dly == 0) begin
               bus.src_valid = 1'b1;
               bus.src_data  = src_a[7:0] ^ 8'h33;
            end
            @(negedge clk);
            bus.src_ack   = 1'b0;
            bus.src_valid = 1'b0;
            bus.src_data  = 8'h00;
            if (val_dly > 0) begin
               repeat (val_dly - 1) @(negedge clk);
               bus.src_valid = 1'b1;
               bus.src_data  = src_a[7:0] ^ 8'h33;
               @(negedge clk);
               bus.src_valid = 1'b0;
               bus.src_data  = 8'h00;
            end
         end
      end
   end

   // Monitor / scoreboard for the WR_GAP=3 instance
   int  cyc = 0;
   int  wr_cnt = 0, done_cnt = 0, req_cnt = 0, run = 0;
   int  last_wr_cyc = -100, done_cyc = 0;
   logic prev_dl = 1'b0, prev_done = 1'b0;
   wr_t got, want;
   always @(negedge clk) begin
      cyc++;
      if (bus.ioctl_wr) begin
         wr_cnt++;
         chk("wr_spacing_ge4", 64'(cyc - last_wr_cyc >= 4), 64'd1);
         chk("wr_with_download", 64'(bus.ioctl_download), 64'd1);
         got.idx = bus.ioctl_index; got.addr = bus.ioctl_addr; got.data = bus.ioctl_data;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_unexpected: got 0x%0h expected no write at %0t", got, $time);
         end else begin
            want = exp_q.pop_front();
            chk("wr_payload", 64'(got), 64'(want));
         end
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
      if (bus.src_req) req_cnt++;
      if (busy && !bus.ioctl_download) run++;
      if (busy && bus.ioctl_download && !prev_dl && run != 0) chk("gap_len", 64'(run), 64'd3);
      if (bus.ioctl_download || !busy) run = 0;
      prev_done = done;
      prev_dl   = bus.ioctl_download;
   end

   // Monitor for the WR_GAP=1 instance
   int  wr1_cnt = 0, done1_cnt = 0, run1 = 0, last1_cyc = 0;
   logic [7:0] last1_idx = 8'd0;
   logic prev_dl1 = 1'b0;
   always @(negedge clk) begin
      if (bus1.ioctl_wr) begin
         wr1_cnt++;
         if (bus1.ioctl_index == 8'd254 && last1_idx == 8'd254)
            chk("g1_dip_spacing", 64'(cyc - last1_cyc), 64'd2);
         if (bus1.ioctl_index == 8'd0)
            chk("g1_rom_data", 64'(bus1.ioctl_data), 64'(bus1.ioctl_addr[7:0] ^ 8'h33));
         last1_cyc = cyc;
         last1_idx = bus1.ioctl_index;
      end
      if (done1) done1_cnt++;
      if (busy1 && !bus1.ioctl_download) run1++;
      if (busy1 && bus1.ioctl_download && !prev_dl1 && run1 != 0) chk("g1_gap_len", 64'(run1), 64'd1);
      if (bus1.ioctl_download || !busy1) run1 = 0;
      prev_dl1 = bus1.ioctl_download;
   end

   task automatic wait_done(input int budget, input string nm);
      int base;
      base = done_cnt;
      for (int i = 0; i < budget && done_cnt == base; i++) @(negedge clk);
      repeat (8) @(negedge clk);
      chk(nm, 64'(done_cnt - base), 64'd1);
   endtask

   task automatic pulse_start(input vec_t v);
      @(negedge clk);
      game_index = v.gi; dip_1 = v.d1; dip_2 = v.d2; rom_len = v.len;
      start = 1'b1;
      push_seq(v.gi, v.d1, v.d2, v.len);
      @(negedge clk);
      start = 1'b0;
      game_index = ~v.gi; dip_1 = ~v.d1; dip_2 = ~v.d2; rom_len = 20'd7;
   endtask

   task automatic run_vec(input vec_t v);
      int base_wr, base_req;
      ack_dly  = v.ack_dly;
      val_dly  = v.val_dly;
      base_wr  = wr_cnt;
      base_req = req_cnt;
      pulse_start(v);
      wait_done(4000, "done_once");
      chk("wr_count", 64'(wr_cnt - base_wr), 64'(v.exp_wr));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("src_req_used", 64'(req_cnt != base_req), 64'(v.len != 20'd0));
      if (v.len == 20'd0) chk("done_after_dip_gap", 64'(done_cyc - last_wr_cyc), 64'd4);
      exp_q.delete();
   endtask

   vec_t vecs[5];
   vec_t v;

   initial begin
      vecs[0] = '{4'h3, 8'h5A, 8'hA5, 20'd4, 0, 1, 13};
      vecs[1] = '{4'h9, 8'h00, 8'hFF, 20'd0, 0, 1, 9};
      vecs[2] = '{4'h7, 8'h11, 8'h22, 20'd3, 10, 5, 12};
      vecs[3] = '{4'hF, 8'h81, 8'h7E, 20'd1, 0, 0, 10};
      vecs[4] = '{4'h0, 8'hC3, 8'h3C, 20'd2, 2, 0, 11};

      reset_n = 1'b0; start = 1'b0; start1 = 1'b0;
      game_index = 4'h0; dip_1 = 8'h00; dip_2 = 8'h00; rom_len = 20'd0; rom_len1 = 20'd2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({busy, done, bus.ioctl_download, bus.ioctl_index, bus.ioctl_addr,
                                bus.ioctl_data, bus.ioctl_wr, bus.src_req, bus.src_addr}), 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // start while busy is ignored
      v = '{4'h5, 8'h12, 8'h34, 20'd5, 2, 1, 14};
      ack_dly = v.ack_dly; val_dly = v.val_dly;
      pulse_start(v);
      repeat (5) @(negedge clk);
      chk("busy_at_restart1", 64'(busy), 64'd1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (50) @(negedge clk);
      chk("busy_at_restart2", 64'(busy), 64'd1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done(4000, "done_once_restart");
      chk("queue_drained_restart", 64'(exp_q.size()), 64'd0);
      exp_q.delete();

      // asynchronous reset in the middle of ROM byte 2
      v = '{4'h6, 8'hAA, 8'h55, 20'd6, 0, 1, 15};
      ack_dly = 0; val_dly = 1;
      pulse_start(v);
      for (int i = 0; i < 600 && !(bus.src_req && bus.src_addr == 20'd2); i++) @(negedge clk);
      chk("reached_rom_byte2", 64'(bus.src_req && bus.src_addr == 20'd2), 64'd1);
      begin
         int dc;
         dc = done_cnt;
         #2 reset_n = 1'b0;
         #1;
         chk("async_reset_outputs", 64'({busy, done, bus.ioctl_download, bus.ioctl_index,
                                         bus.ioctl_addr, bus.ioctl_data, bus.ioctl_wr,
                                         bus.src_req, bus.src_addr}), 64'd0);
         @(posedge clk);
         @(negedge clk);
         reset_n = 1'b1;
         exp_q.delete();
         repeat (6) @(negedge clk);
         chk("no_done_after_abort", 64'(done_cnt - dc), 64'd0);
         chk("idle_after_abort", 64'(busy), 64'd0);
      end
      v = '{4'hA, 8'h01, 8'h02, 20'd2, 0, 1, 11};
      run_vec(v);

      // WR_GAP=1 instance
      @(negedge clk);
      game_index = 4'h2; dip_1 = 8'h3C; dip_2 = 8'hC3;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 500 && done1_cnt == 0; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      chk("g1_done_once", 64'(done1_cnt), 64'd1);
      chk("g1_wr_count", 64'(wr1_cnt), 64'd11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish by %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
